// File: rtl/aes_key_schedule_seq.sv
// Iterative AES key expansion: one 32-bit schedule word per clock for 128/192/256-bit keys.
// Optional macro KS_ROUND_READ_EN adds a registered round-key read port (rd_round/rd_key).
module aes_key_schedule_seq #(
   parameter int unsigned Nb = 4,
   parameter int unsigned Nk = 4,
   parameter int unsigned Nr = 10
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic [32*Nk-1:0]            key,
`ifdef KS_ROUND_READ_EN
   input  logic [3:0]                  rd_round,
   output logic [127:0]                rd_key,
`endif
   output logic                        busy,
   output logic                        done,
   output logic                        valid,
   output logic [0:32*Nb*(Nr+1)-1]     words
);

   localparam int unsigned W  = Nb * (Nr + 1);
   localparam int unsigned IW = $clog2(W);
   localparam int unsigned MW = $clog2(Nk + 1);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXPAND,
      S_DONE
   } state_t;

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   state_t        state;
   logic [31:0]   w [W];
   logic [IW-1:0] idx;
   logic [MW-1:0] kmod;
   logic [7:0]    rcon;

   logic [31:0]   prev_c;
   logic [31:0]   rot_c;
   logic [31:0]   temp_c;
   logic [31:0]   new_word_c;

   // next schedule word w[idx] from w[idx-1] and w[idx-Nk]
   always_comb begin
      prev_c     = w[idx - IW'(1)];
      rot_c      = {prev_c[23:0], prev_c[31:24]};
      temp_c     = prev_c;
      if (kmod == '0) begin
         temp_c = sub_word(rot_c) ^ {rcon, 24'h0};
      end else if ((Nk == 8) && (kmod == MW'(4))) begin
         temp_c = sub_word(prev_c);
      end
      new_word_c = w[idx - IW'(Nk)] ^ temp_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         idx   <= '0;
         kmod  <= '0;
         rcon  <= 8'h01;
         busy  <= 1'b0;
         done  <= 1'b0;
         valid <= 1'b0;
         for (int k = 0; k < W; k++) w[k] <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
               if (start) begin
                  for (int k = 0; k < Nk; k++) w[k] <= key[32*(Nk-1-k) +: 32];
                  idx   <= IW'(Nk);
                  kmod  <= '0;
                  rcon  <= 8'h01;
                  valid <= 1'b0;
                  busy  <= 1'b1;
                  state <= S_EXPAND;
               end
            end
            S_EXPAND: begin
               w[idx] <= new_word_c;
               idx    <= idx + IW'(1);
               kmod   <= (kmod == MW'(Nk - 1)) ? '0 : kmod + MW'(1);
               if (kmod == '0) rcon <= xtime(rcon);
               if (idx == IW'(W - 1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  valid <= 1'b1;
                  state <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // flatten storage onto the word bus; word 0 occupies the most significant slot
   for (genvar g = 0; g < W; g++) begin : g_words
      assign words[32*g +: 32] = w[g];
   end

`ifdef KS_ROUND_READ_EN
   // registered round-key read, one cycle of latency; out-of-range rounds read as zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_key <= '0;
      end else if (rd_round <= 4'(Nr)) begin
         rd_key <= words[128*rd_round +: 128];
      end else begin
         rd_key <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench for aes_key_schedule_seq: AES-128/192/256 instances against an algebraic reference model.
module tb_aes_key_schedule_seq;

   logic         clk;
   logic         rst_n;
   logic [2:0]   start;
   logic [127:0] key4;
   logic [191:0] key6;
   logic [255:0] key8;
   logic [2:0]   busy;
   logic [2:0]   done;
   logic [2:0]   valid;
   logic [0:1407] words4;
   logic [0:1663] words6;
   logic [0:1919] words8;
`ifdef KS_ROUND_READ_EN
   logic [3:0]   rd_round4, rd_round6, rd_round8;
   logic [127:0] rd_key4, rd_key6, rd_key8;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_w [60];

   aes_key_schedule_seq #(.Nb(4), .Nk(4), .Nr(10)) u_ks128 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .key(key4),
`ifdef KS_ROUND_READ_EN
      .rd_round(rd_round4), .rd_key(rd_key4),
`endif
      .busy(busy[0]), .done(done[0]), .valid(valid[0]), .words(words4));

   aes_key_schedule_seq #(.Nb(4), .Nk(6), .Nr(12)) u_ks192 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .key(key6),
`ifdef KS_ROUND_READ_EN
      .rd_round(rd_round6), .rd_key(rd_key6),
`endif
      .busy(busy[1]), .done(done[1]), .valid(valid[1]), .words(words6));

   aes_key_schedule_seq #(.Nb(4), .Nk(8), .Nr(14)) u_ks256 (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .key(key8),
`ifdef KS_ROUND_READ_EN
      .rd_round(rd_round8), .rd_key(rd_key8),
`endif
      .busy(busy[2]), .done(done[2]), .valid(valid[2]), .words(words8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // GF(2^8) arithmetic for the reference S-box: multiplicative inverse plus affine map
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(input logic [7:0] x, input int n);
      return (x << n) | (x >> (8 - n));
   endfunction

   function automatic logic [7:0] sbox_ref(input logic [7:0] x);
      logic [7:0] y = 8'h01;
      for (int k = 0; k < 254; k++) y = gmul(y, x);
      return y ^ rol8(y, 1) ^ rol8(y, 2) ^ rol8(y, 3) ^ rol8(y, 4) ^ 8'h63;
   endfunction

   function automatic logic [31:0] sub_ref(input logic [31:0] x);
      return {sbox_ref(x[31:24]), sbox_ref(x[23:16]), sbox_ref(x[15:8]), sbox_ref(x[7:0])};
   endfunction

   function automatic logic [7:0] rc_ref(input int j);
      logic [7:0] r = 8'h01;
      for (int m = 1; m < j; m++) r = gmul(r, 8'h02);
      return r;
   endfunction

   function automatic void model(input int nk, input logic [255:0] k);
      int wn = 4 * (nk + 7);
      logic [31:0] t;
      for (int i = 0; i < nk; i++) exp_w[i] = k[32*(nk-1-i) +: 32];
      for (int i = nk; i < wn; i++) begin
         t = exp_w[i-1];
         if (i % nk == 0)
            t = sub_ref({t[23:0], t[31:24]}) ^ {rc_ref(i / nk), 24'h0};
         else if (nk == 8 && i % nk == 4)
            t = sub_ref(t);
         exp_w[i] = exp_w[i-nk] ^ t;
      end
   endfunction

   function automatic logic [127:0] exp_rk(input int r);
      return {exp_w[4*r], exp_w[4*r+1], exp_w[4*r+2], exp_w[4*r+3]};
   endfunction

   function automatic logic [127:0] dut_rk(input int sel, input int r);
      case (sel)
         0:       return words4[128*r +: 128];
         1:       return words6[128*r +: 128];
         default: return words8[128*r +: 128];
      endcase
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_key(input int sel, input logic [255:0] k);
      case (sel)
         0:       key4 = k[127:0];
         1:       key6 = k[191:0];
         default: key8 = k;
      endcase
   endtask

   // from the current negedge (cycle n0 after the accept edge), record done pulses until budget
   task automatic watch(input int sel, input int n0, input int budget, output int first, output int pulses);
      first  = -1;
      pulses = 0;
      for (int n = n0; n < budget; n++) begin
         if (done[sel] === 1'b1) begin
            if (first < 0) first = n;
            pulses++;
         end
         @(negedge clk);
      end
   endtask

   task automatic run(input int sel, input logic [255:0] k, input string tag);
      int nk = 4 + 2 * sel;
      int nr = nk + 6;
      int e  = 4 * (nr + 1) - nk;
      int first, pulses;
      model(nk, k);
      set_key(sel, k);
      start[sel] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start[sel] = 1'b0;
      chk({tag, "_busy_on"}, 128'(busy[sel]), 128'd1);
      chk({tag, "_valid_drop"}, 128'(valid[sel]), 128'd0);
      watch(sel, 0, e + 6, first, pulses);
      chk({tag, "_latency"}, 128'(first), 128'(e));
      chk({tag, "_pulses"}, 128'(pulses), 128'd1);
      chk({tag, "_valid"}, 128'(valid[sel]), 128'd1);
      chk({tag, "_busy_off"}, 128'(busy[sel]), 128'd0);
      for (int r = 0; r <= nr; r++)
         chk($sformatf("%s_rk%0d", tag, r), dut_rk(sel, r), exp_rk(r));
   endtask

   initial begin
      logic [255:0] ka, kb;
      int first, pulses;
      start = '0;
      key4  = '0;
      key6  = '0;
      key8  = '0;
`ifdef KS_ROUND_READ_EN
      rd_round4 = '0;
      rd_round6 = '0;
      rd_round8 = '0;
`endif
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_done", 128'(done), 128'd0);
      chk("rst_valid", 128'(valid), 128'd0);
      chk("rst_words", 128'({|words4, |words6, |words8}), 128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      run(0, 256'h000102030405060708090a0b0c0d0e0f, "aes128");
      chk("aes128_rk10_vec", dut_rk(0, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);
      chk("aes128_rk0_key", dut_rk(0, 0), 128'h000102030405060708090a0b0c0d0e0f);
`ifdef KS_ROUND_READ_EN
      rd_round4 = 4'd0;
      @(negedge clk);
      chk("rd_rk0", rd_key4, 128'h000102030405060708090a0b0c0d0e0f);
      rd_round4 = 4'd10;
      @(negedge clk);
      chk("rd_rk10", rd_key4, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      rd_round4 = 4'd15;
      @(negedge clk);
      chk("rd_rk15", rd_key4, 128'd0);
`endif

      run(1, 256'h000102030405060708090a0b0c0d0e0f1011121314151617, "aes192");
      chk("aes192_rk12_vec", dut_rk(1, 12), 128'ha4970a331a78dc09c418c271e3a41d5d);

      run(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, "aes256");
      chk("aes256_rk14_vec", dut_rk(2, 14), 128'h24fc79ccbf0979e9371ac23c6d68de36);
`ifdef KS_ROUND_READ_EN
      rd_round6 = 4'd0;
      rd_round8 = 4'd14;
      @(negedge clk);
      chk("rd192_rk0", rd_key6, 128'h000102030405060708090a0b0c0d0e0f);
      chk("rd256_rk14", rd_key8, 128'h24fc79ccbf0979e9371ac23c6d68de36);
      rd_round6 = 4'd13;
      rd_round8 = 4'd15;
      @(negedge clk);
      chk("rd192_oob", rd_key6, 128'd0);
      chk("rd256_oob", rd_key8, 128'd0);
`endif

      // random keys on every key size
      for (int t = 0; t < 2; t++)
         for (int s = 0; s < 3; s++)
            run(s, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                $sformatf("rnd%0d_%0d", t, s));

      // key change plus start during expansion must be ignored
      ka = {128'd0, $urandom, $urandom, $urandom, $urandom};
      kb = ~ka;
      model(4, ka);
      key4 = ka[127:0];
      start[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start[0] = 1'b0;
      repeat (9) @(negedge clk);
      key4 = kb[127:0];
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      watch(0, 10, 46, first, pulses);
      chk("stab_latency", 128'(first), 128'd40);
      chk("stab_pulses", 128'(pulses), 128'd1);
      for (int r = 0; r <= 10; r++)
         chk($sformatf("stab_rk%0d", r), dut_rk(0, r), exp_rk(r));

      // asynchronous reset in the middle of an expansion
      key4 = {$urandom, $urandom, $urandom, $urandom};
      start[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start[0] = 1'b0;
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_busy", 128'(busy[0]), 128'd0);
      chk("midrst_done", 128'(done[0]), 128'd0);
      chk("midrst_valid", 128'(valid[0]), 128'd0);
      chk("midrst_words", 128'(|words4), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run(0, 256'h2b7e151628aed2a6abf7158809cf4f3c, "fips");
      chk("fips_rk10_vec", dut_rk(0, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
